// File: rtl/pulse_stretcher.sv
// Per-channel pulse stretcher: a trigger sampled high at a rising edge drives
// level_out high for HOLD_CYCLES cycles, with an optional retrigger that
// extends the hold. done_pulse marks the final high cycle of each hold.
module pulse_stretcher #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter bit          RETRIGGER   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pulse_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] done_pulse
);

    localparam int unsigned    CW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HoldCnt = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntZero = '0;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_e          state_q, state_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic            level_q, level_d;
        logic            done_q, done_d;
        logic            trig;

        assign trig = pulse_in[i];

        // Next-state: load on trigger in idle, count down in hold, reload on retrigger.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (trig) begin
                        state_d = StHold;
                        cnt_d   = HoldCnt;
                    end
                end
                StHold: begin
                    if (RETRIGGER && trig) begin
                        cnt_d = HoldCnt;
                    end else if (cnt_q <= CntOne) begin
                        // Last hold cycle is over; the <= keeps the counter from ever wrapping.
                        state_d = StIdle;
                        cnt_d   = CntZero;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end
            endcase
            level_d = (state_d == StHold);
            done_d  = (state_d == StHold) && (cnt_d == CntOne);
        end

        // State and registered outputs; reset aborts any hold without a done strobe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= CntZero;
                level_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                done_q  <= done_d;
            end
        end

        assign level_out[i] = level_q;
        // A retrigger arriving at the edge that would end the hold supersedes the
        // final cycle, so the registered strobe is suppressed while that trigger is present.
        assign done_pulse[i] = done_q & ~(trig & RETRIGGER);
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: five instances with different hold/retrigger
// settings share one stimulus stream; a time-based reference model predicts
// each cycle's outputs into a queue that a negedge monitor drains and checks.
module tb_pulse_stretcher;

    localparam int NI = 5;
    localparam int HC [NI] = '{4, 4, 1, 1, 3};
    localparam int RT [NI] = '{1, 0, 1, 0, 1};

    typedef struct packed {
        logic [NI-1:0][3:0] lv;
        logic [NI-1:0][3:0] dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pulse_in;
    logic [3:0] lv [NI];
    logic [3:0] dn [NI];

    always #5 clk = ~clk;

    pulse_stretcher #(.WIDTH(4), .HOLD_CYCLES(4), .RETRIGGER(1'b1)) u_h4_r1 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .level_out(lv[0]), .done_pulse(dn[0]));
    pulse_stretcher #(.WIDTH(4), .HOLD_CYCLES(4), .RETRIGGER(1'b0)) u_h4_r0 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .level_out(lv[1]), .done_pulse(dn[1]));
    pulse_stretcher #(.WIDTH(4), .HOLD_CYCLES(1), .RETRIGGER(1'b1)) u_h1_r1 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .level_out(lv[2]), .done_pulse(dn[2]));
    pulse_stretcher #(.WIDTH(4), .HOLD_CYCLES(1), .RETRIGGER(1'b0)) u_h1_r0 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .level_out(lv[3]), .done_pulse(dn[3]));
    pulse_stretcher #(.WIDTH(4), .HOLD_CYCLES(3), .RETRIGGER(1'b1)) u_h3_r1 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .level_out(lv[4]), .done_pulse(dn[4]));

    // Reference model: each channel remembers the last cycle index its level is high.
    int         hold_end [NI][4];
    int         t;
    logic [3:0] prev_p;
    logic       prev_r;
    exp_t       exp_q [$];
    int         total;
    int         bad;

    task automatic clear_model();
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++)
                hold_end[i][c] = -10;
    endtask

    // One clock: apply the edge to the model, drive the next inputs, predict this cycle.
    task automatic step(input logic [3:0] p, input logic r);
        exp_t e;
        @(posedge clk);
        t++;
        if (prev_r) begin
            for (int i = 0; i < NI; i++)
                for (int c = 0; c < 4; c++)
                    // Accept if retrigger is allowed or the channel was low the cycle before.
                    if (prev_p[c] && (RT[i] != 0 || (t - 1) > hold_end[i][c]))
                        hold_end[i][c] = t + HC[i] - 1;
        end
        #1;
        rst_n    = r;
        pulse_in = p;
        prev_p   = p;
        prev_r   = r;
        if (!r) clear_model();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 4; c++) begin
                logic high;
                high = (t <= hold_end[i][c]);
                e.lv[i][c] = high;
                e.dn[i][c] = high && (t == hold_end[i][c]) && !(RT[i] != 0 && p[c] && r);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0, 1'b1);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare against the oldest prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                total++;
                if (lv[i] !== e.lv[i]) begin
                    bad++;
                    $display("FAIL level inst%0d cyc%0d got=%b want=%b", i, t, lv[i], e.lv[i]);
                end
                total++;
                if (dn[i] !== e.dn[i]) begin
                    bad++;
                    $display("FAIL done inst%0d cyc%0d got=%b want=%b", i, t, dn[i], e.dn[i]);
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        t        = 0;
        rst_n    = 1'b0;
        pulse_in = 4'h0;
        prev_p   = 4'h0;
        prev_r   = 1'b0;
        clear_model();

        // Triggers during reset are ignored; first edge after release accepts one.
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        step(4'h1, 1'b1);
        idle(8);
        // Single pulse.
        step(4'h1, 1'b1);
        idle(8);
        // Two pulses two edges apart.
        step(4'h1, 1'b1); step(4'h0, 1'b1); step(4'h1, 1'b1);
        idle(8);
        // Pulses at k, k+2, k+4 and k+5 (last one lands on the first idle edge for no-retrigger).
        step(4'h1, 1'b1); step(4'h0, 1'b1); step(4'h1, 1'b1); step(4'h0, 1'b1);
        step(4'h1, 1'b1); step(4'h1, 1'b1);
        idle(8);
        // Reset mid-hold, then a trigger on the first edge after release.
        step(4'h1, 1'b1); step(4'h0, 1'b1); step(4'h0, 1'b0); step(4'h1, 1'b1);
        idle(8);
        // Staggered channels.
        step(4'b0101, 1'b1); step(4'b1010, 1'b1);
        idle(8);
        // Held high for five cycles.
        for (int k = 0; k < 5; k++) step(4'hF, 1'b1);
        idle(6);
        // Held high for a long stretch.
        for (int k = 0; k < 20; k++) step(4'hF, 1'b1);
        idle(6);
        // Random traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            logic [3:0] p;
            logic       r;
            p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            r = ($urandom_range(0, 60) != 0);
            step(p, r);
        end
        idle(6);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
